// File: rtl/vga_fb_arbiter_pkg.sv
// Shared VGA 640x480 timing constants and frame-buffer port state type.
// Imported by the arbiter, its sync generator and the bench.
package vga_pkg;

  localparam logic [9:0] H_ACTIVE     = 10'd640;
  localparam logic [9:0] H_SYNC_START = 10'd656;
  localparam logic [9:0] H_SYNC_END   = 10'd751;
  localparam logic [9:0] H_TOTAL      = 10'd800;
  localparam logic [9:0] V_ACTIVE     = 10'd480;
  localparam logic [9:0] V_SYNC_START = 10'd490;
  localparam logic [9:0] V_SYNC_END   = 10'd491;
  localparam logic [9:0] V_TOTAL      = 10'd525;

  localparam int FB_DEPTH = 307200;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } fb_state_t;

endpackage

// File: rtl/vga_fb_arbiter_if.sv
// Pixel-writer handshake plus the single SRAM port shared by display fetch and writer.
// master = arbiter side, slave = writer/SRAM side.
interface vga_fb_arbiter_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 19
);

  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ack;
  logic              wr_err;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_re;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    input  wr_req, wr_addr, wr_data, mem_rdata,
    output wr_ack, wr_err, mem_addr, mem_re, mem_we, mem_wdata
  );

  modport slave (
    output wr_req, wr_addr, wr_data, mem_rdata,
    input  wr_ack, wr_err, mem_addr, mem_re, mem_we, mem_wdata
  );

endinterface

// File: rtl/vga_sync_gen.sv
// Decodes col/row into active/hsync/vsync/blank and delays them three cycles so they
// line up with the pixel fetched at the same tick.
module vga_sync_gen
  import vga_pkg::*;
(
  input  logic       clk,
  input  logic       n_rst,
  input  logic       pixel_tick,
  input  logic [9:0] col,
  input  logic [9:0] row,
  output logic       active,
  output logic       hsync,
  output logic       vsync,
  output logic       blank
);

  logic       hs_now;
  logic       vs_now;
  // stage layout: {blank, hsync, vsync}
  logic [2:0] s1, s2, s3;

  assign active = (col < H_ACTIVE) && (row < V_ACTIVE);
  assign hs_now = ~((col >= H_SYNC_START) && (col <= H_SYNC_END));
  assign vs_now = ~((row >= V_SYNC_START) && (row <= V_SYNC_END));

  // Only the first stage is tick-gated; later stages shift every cycle so the
  // value sampled at tick N shows up at N+3 and holds until the next tick arrives.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      s1 <= 3'b111;
      s2 <= 3'b111;
      s3 <= 3'b111;
    end else begin
      if (pixel_tick) begin
        s1 <= {~active, hs_now, vs_now};
      end
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign {blank, hsync, vsync} = s3;

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port frame-buffer scheduler: display reads own every active pixel tick, the
// pixel writer takes free cycles. Option macro: VGA_WR_BLANK_ONLY_EN (writes only in vblank).
//
// state | meaning
// IDLE  | SRAM port unused this cycle
// READ  | display fetch on the port (mem_re, addr_enable)
// WRITE | writer access on the port (wr_ack; mem_we unless out of range)
module vga_fb_arbiter
  import vga_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 19,
  parameter int FB_DEPTH = vga_pkg::FB_DEPTH
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              pixel_tick,
  input  logic [9:0]        col,
  input  logic [9:0]        row,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              addr_enable,
  vga_fb_arbiter_if.master  bus,
  output logic              pix_valid,
  output logic [DATA_W-1:0] pix_data,
  output logic              hsync,
  output logic              vsync,
  output logic              blank
);

  localparam logic [ADDR_W-1:0] DEPTH_L = ADDR_W'(FB_DEPTH);

  fb_state_t         state_q, state_nx;
  logic              active;
  logic              read_slot;
  logic              wr_ok;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              err_q;
  logic              rd_pend;

  vga_sync_gen u_sync (
    .clk       (clk),
    .n_rst     (n_rst),
    .pixel_tick(pixel_tick),
    .col       (col),
    .row       (row),
    .active    (active),
    .hsync     (hsync),
    .vsync     (vsync),
    .blank     (blank)
  );

  assign read_slot = pixel_tick & active;

`ifdef VGA_WR_BLANK_ONLY_EN
  assign wr_ok = bus.wr_req && (row >= V_ACTIVE);
`else
  assign wr_ok = bus.wr_req;
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nx;
    end
  end

  // Reads always win; a request still high in its ack cycle is a fresh request.
  always_comb begin
    state_nx = IDLE;
    if (read_slot) begin
      state_nx = READ;
    end else if (wr_ok) begin
      state_nx = WRITE;
    end
  end

  always_comb begin
    addr_enable = 1'b0;
    bus.mem_re  = 1'b0;
    bus.mem_we  = 1'b0;
    bus.wr_ack  = 1'b0;
    bus.wr_err  = 1'b0;
    case (state_q)
      READ: begin
        bus.mem_re  = 1'b1;
        addr_enable = 1'b1;
      end
      WRITE: begin
        bus.wr_ack = 1'b1;
        bus.wr_err = err_q;
        bus.mem_we = ~err_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      err_q     <= 1'b0;
      rd_pend   <= 1'b0;
      pix_valid <= 1'b0;
      pix_data  <= '0;
    end else begin
      rd_pend   <= (state_q == READ);
      pix_valid <= rd_pend;
      pix_data  <= rd_pend ? bus.mem_rdata : '0;
      if (state_nx == READ) begin
        addr_q <= rd_addr;
      end else if (state_nx == WRITE) begin
        addr_q  <= bus.wr_addr;
        wdata_q <= bus.wr_data;
        err_q   <= (bus.wr_addr >= DEPTH_L);
      end
    end
  end

  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Scoreboard bench for vga_fb_arbiter: stimulus pushes expected reads/writes/pixels with
// their expected cycle, a negedge monitor pops and compares on every DUT strobe.
module tb_vga_fb_arbiter;
  import vga_pkg::*;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 19;
  localparam int FRAME_CYC = 8 * 800 * 2;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    int                cyc;
  } rd_exp_t;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              err;
    int                cyc;
  } wr_exp_t;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              blank;
    int                cyc;
  } pix_exp_t;

  logic              clk = 1'b0;
  logic              n_rst = 1'b1;
  logic              pixel_tick = 1'b0;
  logic [9:0]        col = '0;
  logic [9:0]        row = '0;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic              addr_enable;
  logic              pix_valid;
  logic [DATA_W-1:0] pix_data;
  logic              hsync, vsync, blank;

  vga_fb_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  vga_fb_arbiter dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .pixel_tick (pixel_tick),
    .col        (col),
    .row        (row),
    .rd_addr    (rd_addr),
    .addr_enable(addr_enable),
    .bus        (bus),
    .pix_valid  (pix_valid),
    .pix_data   (pix_data),
    .hsync      (hsync),
    .vsync      (vsync),
    .blank      (blank)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  rd_exp_t  rd_q[$];
  wr_exp_t  wr_q[$];
  pix_exp_t pix_q[$];
  logic [ADDR_W-1:0] exp_rd = '0;

  int frame_c0 = 32'h7fff_0000;
  int ae_cnt = 0, hs_lo = 0, vs_lo = 0, bl_hi = 0;
  int frame_rows[8] = '{478, 479, 480, 481, 489, 490, 491, 492};

  function automatic logic [DATA_W-1:0] sram_val(input logic [ADDR_W-1:0] a);
    return a[7:0] ^ 8'hA5;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // SRAM model: data for an address read in cycle k is presented during cycle k+1.
  logic              re_seen = 1'b0;
  logic [ADDR_W-1:0] addr_seen = '0;
  always @(negedge clk) begin
    re_seen   = bus.mem_re;
    addr_seen = bus.mem_addr;
  end
  always @(posedge clk) begin
    #1;
    bus.mem_rdata = re_seen ? sram_val(addr_seen) : 8'h00;
  end

  // External frame address counter, advanced by addr_enable.
  always @(negedge clk) begin
    if (addr_enable) rd_addr <= (rd_addr == ADDR_W'(FB_DEPTH - 1)) ? '0 : rd_addr + 1'b1;
  end

  rd_exp_t  re;
  wr_exp_t  we;
  pix_exp_t pe;
  always @(negedge clk) begin
    if (n_rst) begin
      if (bus.mem_re) begin
        if (rd_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL mem_re_unexpected: read of %0h, expected no read", bus.mem_addr);
        end else begin
          re = rd_q.pop_front();
          chk("mem_read", 64'({bus.mem_addr, bus.mem_we, addr_enable, 32'(cyc)}),
              64'({re.addr, 1'b0, 1'b1, 32'(re.cyc)}));
        end
      end else if (addr_enable) begin
        checks++; errors++;
        $display("FAIL addr_enable_stray: addr_enable=1 without mem_re, expected 0");
      end
      if (bus.wr_ack) begin
        if (wr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL wr_ack_unexpected: ack addr %0h, expected no ack", bus.mem_addr);
        end else begin
          we = wr_q.pop_front();
          chk("wr_ack", 64'({bus.mem_we, bus.wr_err, 32'(cyc)}), 64'({~we.err, we.err, 32'(we.cyc)}));
          if (!we.err) chk("wr_data", 64'({bus.mem_addr, bus.mem_wdata}), 64'({we.addr, we.data}));
        end
      end else if (bus.mem_we) begin
        checks++; errors++;
        $display("FAIL mem_we_stray: mem_we=1 without wr_ack, expected 0");
      end
      if (pix_valid) begin
        if (pix_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL pix_unexpected: pix_data %0h, expected no pixel", pix_data);
        end else begin
          pe = pix_q.pop_front();
          chk("pixel", 64'({pix_data, blank, 32'(cyc)}), 64'({pe.data, pe.blank, 32'(pe.cyc)}));
        end
      end
      if (cyc >= frame_c0 && cyc < frame_c0 + FRAME_CYC + 4 && addr_enable) ae_cnt++;
      if (cyc >= frame_c0 + 3 && cyc < frame_c0 + 3 + FRAME_CYC) begin
        if (!hsync) hs_lo++;
        if (!vsync) vs_lo++;
        if (blank) bl_hi++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_read();
    rd_q.push_back('{exp_rd, cyc + 1});
    pix_q.push_back('{sram_val(exp_rd), 1'b0, cyc + 3});
    exp_rd = exp_rd + 1'b1;
  endtask

  task automatic wait_ack();
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      pixel_tick = 1'b0;
      if (bus.wr_ack) begin
        bus.wr_req = 1'b0;
        seen = 1'b1;
      end
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL wr_ack_timeout: no ack within 40 cycles, expected one");
      bus.wr_req = 1'b0;
    end
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                          input logic err, input int lat);
    bus.wr_req  = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    wr_q.push_back('{a, d, err, cyc + lat});
    wait_ack();
  endtask

  task automatic chk_reset(input string name);
    chk(name, 64'({addr_enable, bus.wr_ack, bus.wr_err, bus.mem_re, bus.mem_we, pix_valid,
                   hsync, vsync, blank, bus.mem_addr, bus.mem_wdata, pix_data}),
        64'({9'b000000111, 35'd0}));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.wr_req    = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    bus.mem_rdata = '0;
    #2 n_rst = 1'b0;
    #1 chk_reset("reset_values");
    @(posedge clk);
    @(posedge clk);
    #1 n_rst = 1'b1;
    step(); step();

    // display reads at col 0 and 1 of row 0
    col = 10'd0; row = 10'd0; pixel_tick = 1'b1; push_read();
    step(); pixel_tick = 1'b0; step();
    col = 10'd1; pixel_tick = 1'b1; push_read();
    step(); pixel_tick = 1'b0; step(); step(); step();

    // single writes in free cycles, in-range boundary and out-of-range
    col = 10'd0; row = V_ACTIVE;
    do_write(19'h00010, 8'h3C, 1'b0, 1); step();
    do_write(19'h4B000, 8'h77, 1'b1, 1); step();
    do_write(19'h4AFFF, 8'h78, 1'b0, 1); step();

    // back-to-back writes: request held through the first ack
    bus.wr_req = 1'b1; bus.wr_addr = 19'h00020; bus.wr_data = 8'h11;
    wr_q.push_back('{19'h00020, 8'h11, 1'b0, cyc + 1});
    step();
    bus.wr_addr = 19'h00021; bus.wr_data = 8'h22;
    wr_q.push_back('{19'h00021, 8'h22, 1'b0, cyc + 1});
    step();
    bus.wr_req = 1'b0;
    step();

`ifndef VGA_WR_BLANK_ONLY_EN
    // write request collides with an active tick: read first, write next cycle
    col = 10'd5; row = 10'd10; pixel_tick = 1'b1; push_read();
    do_write(19'h00100, 8'h5A, 1'b0, 2);
    step();
`else
    // request during an active row waits until vertical blanking
    col = 10'd0; row = 10'd100;
    bus.wr_req = 1'b1; bus.wr_addr = 19'h00200; bus.wr_data = 8'h42;
    repeat (10) step();
    chk("blank_only_hold", 64'(bus.wr_ack), 64'(0));
    row = V_ACTIVE;
    wr_q.push_back('{19'h00200, 8'h42, 1'b0, cyc + 1});
    wait_ack();
    step();
`endif

    // tick in horizontal sync outside the active region: no read, sync flags at N+3
    col = 10'd700; row = 10'd10; pixel_tick = 1'b1;
    step(); pixel_tick = 1'b0; step(); step();
    chk("blank_tick_sync", 64'({blank, hsync, vsync}), 64'(3'b101));

    // reset in the WRITE cycle drops the ack; the held request is re-granted after reset
    col = 10'd0; row = V_ACTIVE;
    bus.wr_req = 1'b1; bus.wr_addr = 19'h00123; bus.wr_data = 8'h99;
    step();
    #2 n_rst = 1'b0;
    #1 chk_reset("reset_mid_write");
    step();
    n_rst = 1'b1;
    wr_q.push_back('{19'h00123, 8'h99, 1'b0, cyc + 1});
    wait_ack();
    step();

    // eight full lines around the active/vsync boundaries with the tick every 2nd clk
    frame_c0 = cyc;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 800; c++) begin
        row = 10'(frame_rows[r]);
        col = 10'(c);
        pixel_tick = 1'b1;
        if (c < 640 && frame_rows[r] < 480) push_read();
        step();
        pixel_tick = 1'b0;
        step();
      end
    end
    repeat (8) step();
    chk("frame_addr_enable", 64'(ae_cnt), 64'(1280));
    chk("frame_hsync_low", 64'(hs_lo), 64'(1536));
    chk("frame_vsync_low", 64'(vs_lo), 64'(3200));
    chk("frame_blank_high", 64'(bl_hi), 64'(10240));
    chk("rd_addr_advance", 64'(rd_addr), 64'(exp_rd));

    repeat (5) step();
    chk("queues_drained", 64'(rd_q.size() + wr_q.size() + pix_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
- Single-port frame-buffer scheduler for the VGA path.
- Shares one synchronous SRAM port between two users:
  - display fetch, slotted by the pixel-tick (clock-divider flag) and the col/row timing counters;
  - a pixel writer (capture/shift-register side).
- Drives the 19-bit frame address counter's enable; generates registered hsync/vsync/blank aligned to the fetched pixel.

Parameters:
- DATA_W, 8, pixel/memory data width.
- ADDR_W, 19, frame-buffer address width.
- FB_DEPTH, 307200, number of valid addresses (640x480).

Ports:
- clk  in  1  system clock.
- n_rst  in  1  asynchronous active-low reset.
- pixel_tick  in  1  one-cycle pulse every 2nd clk (clock-divider flag).
- col  in  10  column counter, 0..799.
- row  in  10  row counter, 0..524.
- rd_addr  in  ADDR_W  current frame address counter value.
- addr_enable  out  1  advance frame address counter.
- wr_req  in  1  write request; held until wr_ack.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- wr_ack  out  1  one-cycle write completion.
- wr_err  out  1  qualifies wr_ack: address out of range, no write done.
- mem_addr  out  ADDR_W  SRAM address.
- mem_re  out  1  SRAM read strobe.
- mem_we  out  1  SRAM write strobe.
- mem_wdata  out  DATA_W  SRAM write data.
- mem_rdata  in  DATA_W  SRAM read data, valid the cycle after mem_re.
- pix_valid  out  1  pix_data valid.
- pix_data  out  DATA_W  fetched pixel; 0 when blank.
- hsync  out  1  active-low.
- vsync  out  1  active-low.
- blank  out  1  high outside the active region.

Behaviour:
- Reset values: all outputs 0 except hsync=1, vsync=1, blank=1. Reset mid-access aborts it: no wr_ack issued, and the held request is re-arbitrated after reset.
- Active region: col<640 and row<480.
- Read slot: cycle N where pixel_tick=1 and the active region holds.
- FSM states: IDLE, READ, WRITE. The state names what the SRAM port carries in the current cycle.
- Grant decision in cycle N (combinational):
  - read slot -> READ;
  - else wr_req and no write in flight -> WRITE;
  - else IDLE.
- Reads always win. Writes cannot starve, because a read slot occurs at most every 2nd cycle.
- READ (cycle N+1):
  - mem_re=1, mem_addr=rd_addr sampled at N;
  - addr_enable=1 for exactly one cycle, so the counter advances at N+2.
- Data return:
  - mem_rdata sampled at N+2;
  - pix_data/pix_valid registered, visible at N+3;
  - pix_valid is a one-cycle pulse.
- WRITE (cycle N+1):
  - in range (wr_addr<FB_DEPTH): mem_we=1, mem_addr=wr_addr, mem_wdata=wr_data, wr_ack=1;
  - wr_addr>=FB_DEPTH: wr_ack=1, wr_err=1, mem_we=0.
- Write request rules:
  - wr_req may deassert the cycle after wr_ack;
  - a still-high wr_req in the ack cycle counts as a new request;
  - back-to-back writes are allowed when no read slot intervenes (one per cycle after the first grant).
- mem_re and mem_we are never both high.
- Sync timing:
  - hsync low for col 656..751;
  - vsync low for row 490..491;
  - blank = not active.
  - All three are computed from col/row at the tick, then delayed to appear at N+3 with pix_data.
  - Non-tick cycles hold the previous values.
- Frame wrap: the address counter rolls over externally at FB_DEPTH-1. The block issues exactly 307200 addr_enable pulses per frame.

Optional Feature:
- Macro: VGA_WR_BLANK_ONLY_EN.
- Defined: WRITE is granted only while row>=480 (vertical blanking), giving tear-free updates. Requests made during active rows wait, and wr_ack may be delayed up to one frame.
- Undefined: writes interleave with reads in any free cycle, as above.

Decomposition:
- Package vga_pkg: H_ACTIVE=640, H_SYNC_START=656, H_SYNC_END=751, H_TOTAL=800, V_ACTIVE=480, V_SYNC_START=490, V_SYNC_END=491, V_TOTAL=525, FB_DEPTH, and enum fb_state_t {IDLE, READ, WRITE}.
- Sub-module vga_sync_gen: col/row -> active/hsync/vsync decode plus the 3-stage alignment delay.

Test Plan:
- Tick at col=0,row=0, rd_addr=0, mem_rdata=0xA5 -> mem_re and addr_enable at N+1 with mem_addr=0; pix_valid=1, pix_data=0xA5, blank=0 at N+3.
- wr_req, wr_addr=0x00010, wr_data=0x3C in a non-tick cycle -> mem_we=1, mem_wdata=0x3C, wr_ack=1, wr_err=0 next cycle.
- wr_req asserted in the same cycle as an active tick -> READ first; WRITE the following cycle; mem_re and mem_we never overlap.
- wr_addr=0x4B000 -> wr_ack=1, wr_err=1, mem_we stays 0.
- Full frame with the counters running -> 307200 addr_enable pulses; hsync low for 96 ticks per line; vsync low on rows 490..491; blank=1 for col>=640.
- n_rst low during WRITE -> all outputs at reset values, no wr_ack. With VGA_WR_BLANK_ONLY_EN, a request at row=100 is acked only once row>=480.
